// File: rtl/sprite_blit.sv
// CHIP-8/SCHIP DXYN sprite engine: row fetch, XOR read-modify-write into 2-bit vram.
// Optional SPRITE_WRAP_EN: wrap pixels at logical edges instead of clipping.
module sprite_blit #(
  parameter int VW = 128,
  parameter int VH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        hires,
  input  logic [6:0]  x,
  input  logic [5:0]  y,
  input  logic [3:0]  n,
  input  logic [11:0] i_addr,
  input  logic [1:0]  plane,
  output logic [11:0] ram_addr,
  input  logic [7:0]  ram_dout,
  output logic [6:0]  vram_hpos,
  output logic [5:0]  vram_vpos,
  input  logic [1:0]  vram_pixelo,
  output logic [1:0]  vram_pixeli,
  output logic        vram_we,
  output logic        busy,
  output logic        done,
  output logic        collision
);

  localparam logic [7:0] LW = 8'(VW);
  localparam logic [6:0] LH = 7'(VH);

  typedef enum logic [2:0] {
    IDLE, FETCH, SCAN, RD, WAIT, WR, NEXT, FIN
  } state_t;

  state_t      st;
  logic        hr;
  logic        wide;
  logic [4:0]  rows;
  logic [6:0]  x0;
  logic [5:0]  y0;
  logic [1:0]  pl;
  logic [15:0] sh;
  logic [3:0]  c;
  logic [4:0]  r;
  logic [1:0]  sub;
  logic [1:0]  fph;

  logic [7:0]  px;
  logic [6:0]  py;
  logic [6:0]  pyn;
  logic [4:0]  rn;
  logic [1:0]  tsub;
  logic [6:0]  th;
  logic [5:0]  tv;
  logic        clip;
  logic        bottom;
  logic        last_col;
  logic        last_row;
  logic        last_sub;

  // target pixel, clip and loop-end decode for the current column/row
  always_comb begin
    px = {1'b0, x0} + {4'd0, c};
    py = {1'b0, y0} + {2'd0, r};
    rn = r + 5'd1;
    pyn = {1'b0, y0} + {2'd0, rn};
    tsub = (st == WR) ? sub + 2'd1 : 2'd0;
    th = hr ? px[6:0] : {px[5:0], tsub[0]};
    tv = hr ? py[5:0] : {py[4:0], tsub[1]};
`ifdef SPRITE_WRAP_EN
    clip = 1'b0;
    bottom = 1'b0;
`else
    clip = hr ? (px >= LW || py >= LH)
              : (px >= (LW >> 1) || py >= (LH >> 1));
    bottom = hr ? (pyn >= LH) : (pyn >= (LH >> 1));
`endif
    last_col = (c == (wide ? 4'd15 : 4'd7));
    last_row = (rn == rows) || bottom;
    last_sub = hr || (sub == 2'd3);
  end

  // draw sequencer with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
      hr <= 1'b0;
      wide <= 1'b0;
      rows <= '0;
      x0 <= '0;
      y0 <= '0;
      pl <= '0;
      sh <= '0;
      c <= '0;
      r <= '0;
      sub <= '0;
      fph <= '0;
      ram_addr <= '0;
      vram_hpos <= '0;
      vram_vpos <= '0;
      vram_pixeli <= '0;
      vram_we <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      collision <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            hr <= hires;
            wide <= hires && (n == 4'd0);
            rows <= (n == 4'd0) ? 5'd16 : {1'b0, n};
            x0 <= hires ? x : {1'b0, x[5:0]};
            y0 <= hires ? y : {1'b0, y[4:0]};
            pl <= (plane == 2'b00) ? 2'b01 : plane;
            ram_addr <= i_addr;
            collision <= 1'b0;
            busy <= 1'b1;
            c <= '0;
            r <= '0;
            fph <= '0;
            st <= FETCH;
          end
        end
        FETCH: begin
          unique case (fph)
            2'd0: begin
              ram_addr <= ram_addr + 12'd1;
              fph <= 2'd1;
            end
            2'd1: begin
              sh <= {ram_dout, 8'h00};
              if (wide) begin
                ram_addr <= ram_addr + 12'd1;
                fph <= 2'd2;
              end else begin
                fph <= 2'd0;
                st <= SCAN;
              end
            end
            default: begin
              sh[7:0] <= ram_dout;
              fph <= 2'd0;
              st <= SCAN;
            end
          endcase
        end
        SCAN: begin
          if (sh[15] && !clip) begin
            vram_hpos <= th;
            vram_vpos <= tv;
            sub <= 2'd0;
            st <= RD;
          end else if (last_col) begin
            st <= NEXT;
          end else begin
            c <= c + 4'd1;
            sh <= sh << 1;
          end
        end
        RD: st <= WAIT;
        WAIT: begin
          vram_pixeli <= vram_pixelo ^ pl;
          vram_we <= 1'b1;
          if ((vram_pixelo & pl) != 2'b00) collision <= 1'b1;
          st <= WR;
        end
        WR: begin
          vram_we <= 1'b0;
          if (!last_sub) begin
            sub <= sub + 2'd1;
            vram_hpos <= th;
            vram_vpos <= tv;
            st <= RD;
          end else if (last_col) begin
            st <= NEXT;
          end else begin
            c <= c + 4'd1;
            sh <= sh << 1;
            st <= SCAN;
          end
        end
        NEXT: begin
          c <= '0;
          r <= rn;
          if (last_row) begin
            done <= 1'b1;
            busy <= 1'b0;
            st <= FIN;
          end else begin
            st <= FETCH;
          end
        end
        default: begin
          done <= 1'b0;
          st <= IDLE;
        end
      endcase
    end
  end

endmodule
